// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Conditions the board push-buttons for the guessing-game controller. Each
// button is synchronised, debounced, and presented as a clean active-high
// level with single-cycle press and release strobes. Every bit is handled by
// its own independent synchroniser, debounce FSM and counter.
//
// Optional build macro: BTN_AUTOREPEAT_EN
//   When defined, a held button produces extra press_pulse strobes:
//   REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
//   When undefined, no hold counter exists and each debounced press yields
//   exactly one press_pulse.
//
// Ports:
//   clk50M        in   1      50 MHz system clock, rising edge
//   reset         in   1      synchronous active-high reset
//   btn_n         in   N_BTN  raw asynchronous buttons, 0 = pressed
//   level         out  N_BTN  debounced state, 1 = pressed
//   press_pulse   out  N_BTN  one-cycle strobe on 0->1 (plus auto-repeats)
//   release_pulse out  N_BTN  one-cycle strobe on 1->0
// -----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk50M,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse
);

`ifdef BTN_AUTOREPEAT_EN
   // Debounce and hold counters share one width sized for the larger range.
   localparam int MAX_CNT = (REPEAT_DELAY > DEBOUNCE_CYCLES) ? REPEAT_DELAY
                                                             : DEBOUNCE_CYCLES;
`else
   // Repeat parameters have no effect in this build; the zero-weighted term
   // only keeps them referenced.
   localparam int MAX_CNT = DEBOUNCE_CYCLES + 0 * (REPEAT_DELAY + REPEAT_PERIOD);
`endif
   localparam int CNT_W = $clog2(MAX_CNT);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } state_t;

   // Synchroniser holds the inverted (active-high) button value, so the
   // released state is 0 in both stages.
   logic [N_BTN-1:0] s1_reg;
   logic [N_BTN-1:0] s2_reg;

   always_ff @(posedge clk50M) begin
      if (reset) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= ~btn_n;
         s2_reg <= s1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_bit
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg,   cnt_next;
         logic             level_reg, level_next;
         logic             press_reg, press_next;
         logic             rel_reg,   rel_next;
         logic             toggle;

         always_ff @(posedge clk50M) begin
            if (reset) begin
               state_reg <= ST_STABLE;
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
               rel_reg   <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               level_reg <= level_next;
               press_reg <= press_next;
               rel_reg   <= rel_next;
            end
         end

`ifdef BTN_AUTOREPEAT_EN
         logic [CNT_W-1:0] hold_reg, hold_next;

         always_ff @(posedge clk50M) begin
            if (reset) hold_reg <= '0;
            else       hold_reg <= hold_next;
         end
`endif

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            level_next = level_reg;
            press_next = 1'b0;
            rel_next   = 1'b0;
            toggle     = 1'b0;

            case (state_reg)
               ST_STABLE: begin
                  if (s2_reg[gi] != level_reg) begin
                     cnt_next   = CNT_W'(1);
                     state_next = ST_COUNTING;
                  end
               end
               ST_COUNTING: begin
                  if (s2_reg[gi] == level_reg) begin
                     // Bounce: discard the partial count entirely.
                     cnt_next   = '0;
                     state_next = ST_STABLE;
                  end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                     toggle     = 1'b1;
                     level_next = ~level_reg;
                     press_next = ~level_reg;
                     rel_next   = level_reg;
                     cnt_next   = '0;
                     state_next = ST_STABLE;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
               default: begin
                  cnt_next   = '0;
                  state_next = ST_STABLE;
               end
            endcase

`ifdef BTN_AUTOREPEAT_EN
            // hold_reg equals (cycles since press - 1); a repeat fires when it
            // reaches REPEAT_DELAY-1 and is then rewound so the next repeat
            // lands REPEAT_PERIOD cycles later. A toggle edge (the release)
            // clears it, so no repeat can coincide with release_pulse.
            hold_next = hold_reg;
            if (!level_reg || toggle) begin
               hold_next = '0;
            end else if (hold_reg == CNT_W'(REPEAT_DELAY - 1)) begin
               hold_next  = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
               press_next = 1'b1;
            end else begin
               hold_next = hold_reg + CNT_W'(1);
            end
`endif
         end

         assign level[gi]         = level_reg;
         assign press_pulse[gi]   = press_reg;
         assign release_pulse[gi] = rel_reg;
      end
   endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5). Stimulus pushes the expected pulse events (edge number,
// press/release vectors, level) into a queue; a monitor pops and compares one
// event whenever the DUT raises any pulse. Define BTN_AUTOREPEAT_EN for both
// RTL and bench to exercise the auto-repeat build.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

   localparam int N   = 3;
   localparam int DB  = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;
   localparam int LAT = DB + 2;   // edges from input change to level update

   logic         clk50M = 1'b0;
   logic         reset  = 1'b1;
   logic [N-1:0] btn_n  = 3'b111;
   logic [N-1:0] level;
   logic [N-1:0] press_pulse;
   logic [N-1:0] release_pulse;

   btn_conditioner #(
      .N_BTN          (N),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk50M       (clk50M),
      .reset        (reset),
      .btn_n        (btn_n),
      .level        (level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   always #10 clk50M = ~clk50M;

   typedef struct {
      int           at_edge;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] lvl;
   } ev_t;

   ev_t exp_q[$];
   int  edge_cnt = 0;
   int  errors   = 0;
   int  checks   = 0;
   bit  mon_en   = 1'b0;

   always @(posedge clk50M) edge_cnt <= edge_cnt + 1;

   // Monitor: every cycle showing a pulse must match the next expected event.
   always @(negedge clk50M) begin
      ev_t ev;
      if (mon_en && ((press_pulse | release_pulse) != 3'b000)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse edge=%0d press=%b release=%b level=%b",
                     edge_cnt, press_pulse, release_pulse, level);
         end else begin
            ev = exp_q.pop_front();
            if (ev.at_edge != edge_cnt || ev.press !== press_pulse ||
                ev.rel !== release_pulse || ev.lvl !== level) begin
               errors++;
               $display("FAIL pulse_event got edge=%0d press=%b release=%b level=%b want edge=%0d press=%b release=%b level=%b",
                        edge_cnt, press_pulse, release_pulse, level,
                        ev.at_edge, ev.press, ev.rel, ev.lvl);
            end else begin
               $display("event edge=%0d press=%b release=%b level=%b ok",
                        edge_cnt, press_pulse, release_pulse, level);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   task automatic push(input int at, input logic [N-1:0] p,
                       input logic [N-1:0] r, input logic [N-1:0] l);
      ev_t ev;
      ev.at_edge = at;
      ev.press   = p;
      ev.rel     = r;
      ev.lvl     = l;
      exp_q.push_back(ev);
   endtask

   task automatic check_lvl(input string name, input logic [N-1:0] want);
      checks++;
      if (level !== want) begin
         errors++;
         $display("FAIL %s level=%b want=%b", name, level, want);
      end else begin
         $display("check %s level=%b ok", name, level);
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if (level !== 3'b000 || press_pulse !== 3'b000 || release_pulse !== 3'b000) begin
         errors++;
         $display("FAIL %s level=%b press=%b release=%b want all 000",
                  name, level, press_pulse, release_pulse);
      end else begin
         $display("check %s outputs 000 ok", name);
      end
   endtask

   initial begin
      int t0;

      // Reset state.
      step(3);
      check_quiet("reset_state");
      mon_en = 1'b1;
      reset  = 1'b0;

      // Idle: no pulses for 20 cycles.
      step(20);
      check_lvl("idle", 3'b000);

      // Clean press of button 1, accepted 6 edges later.
      t0 = edge_cnt;
      btn_n = 3'b101;
      push(t0 + LAT, 3'b010, 3'b000, 3'b010);
      step(10);
      check_lvl("b1_held", 3'b010);

      // Bouncing button 0 never reaches the full count.
      btn_n[0] = 1'b0; step(3);
      btn_n[0] = 1'b1; step(1);
      btn_n[0] = 1'b0; step(3);
      btn_n[0] = 1'b1; step(12);
      check_lvl("bounce_rejected", 3'b010);

      // Release button 1.
      t0 = edge_cnt;
      btn_n = 3'b111;
      push(t0 + LAT, 3'b000, 3'b010, 3'b000);
      step(10);
      check_lvl("b1_released", 3'b000);

      // Button 2 press then release.
      t0 = edge_cnt;
      btn_n = 3'b011;
      push(t0 + LAT, 3'b100, 3'b000, 3'b100);
      step(10);
      check_lvl("b2_held", 3'b100);
      t0 = edge_cnt;
      btn_n = 3'b111;
      push(t0 + LAT, 3'b000, 3'b100, 3'b000);
      step(10);
      check_lvl("b2_released", 3'b000);

      // Buttons 0 and 2 together: both pulse on the same edge.
      t0 = edge_cnt;
      btn_n = 3'b010;
      push(t0 + LAT, 3'b101, 3'b000, 3'b101);
      step(10);
      check_lvl("b02_held", 3'b101);
      t0 = edge_cnt;
      btn_n = 3'b111;
      push(t0 + LAT, 3'b000, 3'b101, 3'b000);
      step(10);
      check_lvl("b02_released", 3'b000);

      // Reset while button 0 is mid-count (cnt=2 after 4 edges).
      btn_n = 3'b110;
      step(4);
      reset = 1'b1;
      step(1);
      check_quiet("reset_mid_count_a");
      step(1);
      check_quiet("reset_mid_count_b");
      t0 = edge_cnt;
      reset = 1'b0;
      push(t0 + LAT, 3'b001, 3'b000, 3'b001);
      step(3);
      check_lvl("after_reset_pending", 3'b000);
      step(7);
      check_lvl("after_reset_accepted", 3'b001);
      t0 = edge_cnt;
      btn_n = 3'b111;
      push(t0 + LAT, 3'b000, 3'b001, 3'b000);
      step(10);

      // Long hold of button 1: release sampled at edge 36, level falls at 41.
      t0 = edge_cnt;
      btn_n = 3'b101;
      push(t0 + 6, 3'b010, 3'b000, 3'b010);
`ifdef BTN_AUTOREPEAT_EN
      push(t0 + 16, 3'b010, 3'b000, 3'b010);
      push(t0 + 21, 3'b010, 3'b000, 3'b010);
      push(t0 + 26, 3'b010, 3'b000, 3'b010);
      push(t0 + 31, 3'b010, 3'b000, 3'b010);
      push(t0 + 36, 3'b010, 3'b000, 3'b010);
`endif
      // Edge 41 would be a repeat slot but the release wins.
      push(t0 + 41, 3'b000, 3'b010, 3'b000);
      step(35);
      check_lvl("long_hold", 3'b010);
      btn_n = 3'b111;
      step(20);
      check_lvl("long_hold_released", 3'b000);

      // Every expected event must have been seen.
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events outstanding=%0d want=0 next_edge=%0d",
                  exp_q.size(), exp_q[0].at_edge);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
